// File: rtl/gf180mcu_fd_sc_mcu7t5v0__arb33_1_pkg.sv
// Shared types and constants for the two-group, three-requester arbiter.
// Also provides a helper that converts a one-hot winner into a pointer value.
package gf180mcu_fd_sc_mcu7t5v0__arb33_1_pkg;

  localparam int unsigned HoldCntW = 4;
  localparam logic [1:0]  PtrRst   = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StRecover
  } state_e;

  typedef enum logic {
    GrpA = 1'b0,
    GrpB = 1'b1
  } grp_e;

  // Pointer values are 1..3, naming the requester that won last.
  function automatic logic [1:0] onehot_to_ptr(input logic [2:0] oh);
    logic [1:0] ptr;
    ptr = 2'd3;
    if (oh[0]) ptr = 2'd1;
    else if (oh[1]) ptr = 2'd2;
    return ptr;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rr3pick.sv
// Combinational round-robin picker for three requesters.
// Grants the first requester after ptr in cyclic order 1->2->3->1.
module gf180mcu_fd_sc_mcu7t5v0__rr3pick (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic       valid
);

  always_comb begin
    gnt = 3'b000;
    case (ptr)
      2'd1: begin
        if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd2: begin
        if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__arb33_1.sv
// Two-group arbiter with bounded grant tenure and a one-cycle all-low gap between grants.
// Groups alternate on contention; within a group requesters rotate round-robin.
module gf180mcu_fd_sc_mcu7t5v0__arb33_1
  import gf180mcu_fd_sc_mcu7t5v0__arb33_1_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  output logic GA1,
  output logic GA2,
  output logic GA3,
  output logic GB1,
  output logic GB2,
  output logic GB3,
  output logic BUSY,
  output logic CONFLICTN,
  inout  wire  VDD,
  inout  wire  VSS
);

  localparam logic [HoldCntW-1:0] HoldLast = HoldCntW'(HOLD_MAX - 1);

  logic [2:0]          req_a, req_b;
  logic [2:0]          gnt_a, gnt_b;
  logic                valid_a, valid_b;
  state_e              state_q;
  logic [2:0]          ga_q, gb_q;
  logic                busy_q, conflictn_q;
  logic [HoldCntW-1:0] holdcnt_q;
  logic [1:0]          ptr_a_q, ptr_b_q;
  grp_e                lastgrp_q;
  logic                win_b, any_req, held_req, end_tenure;
  logic                unused_supply;

  assign req_a = {A3, A2, A1};
  assign req_b = {B3, B2, B1};
  assign unused_supply = VDD ^ VSS;

  gf180mcu_fd_sc_mcu7t5v0__rr3pick u_pick_a (
    .req   (req_a),
    .ptr   (ptr_a_q),
    .gnt   (gnt_a),
    .valid (valid_a)
  );

  gf180mcu_fd_sc_mcu7t5v0__rr3pick u_pick_b (
    .req   (req_b),
    .ptr   (ptr_b_q),
    .gnt   (gnt_b),
    .valid (valid_b)
  );

  // On contention the group that did not win last time takes the grant.
  assign win_b      = valid_b && (!valid_a || (lastgrp_q == GrpA));
  assign any_req    = valid_a || valid_b;
  assign held_req   = (|(ga_q & req_a)) || (|(gb_q & req_b));
  assign end_tenure = !held_req || (holdcnt_q == HoldLast);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      ga_q        <= 3'b000;
      gb_q        <= 3'b000;
      busy_q      <= 1'b0;
      conflictn_q <= 1'b1;
      holdcnt_q   <= '0;
      ptr_a_q     <= PtrRst;
      ptr_b_q     <= PtrRst;
      lastgrp_q   <= GrpB;
    end else begin
      conflictn_q <= !(valid_a && valid_b);
      case (state_q)
        StGrant: begin
          if (end_tenure) begin
            state_q <= StRecover;
            ga_q    <= 3'b000;
            gb_q    <= 3'b000;
            busy_q  <= 1'b0;
          end else begin
            holdcnt_q <= holdcnt_q + 1'b1;
          end
        end
        default: begin
          if (any_req) begin
            state_q   <= StGrant;
            holdcnt_q <= '0;
            busy_q    <= 1'b1;
            if (win_b) begin
              ga_q      <= 3'b000;
              gb_q      <= gnt_b;
              ptr_b_q   <= onehot_to_ptr(gnt_b);
              lastgrp_q <= GrpB;
            end else begin
              ga_q      <= gnt_a;
              gb_q      <= 3'b000;
              ptr_a_q   <= onehot_to_ptr(gnt_a);
              lastgrp_q <= GrpA;
            end
          end else begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign {GA3, GA2, GA1} = ga_q;
  assign {GB3, GB2, GB1} = gb_q;
  assign BUSY            = busy_q;
  assign CONFLICTN       = conflictn_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__arb33_1.sv
// Directed bench for the two-group arbiter: default HOLD_MAX instance plus a HOLD_MAX=4 instance.
// Expected values are hand-derived from the arbitration rules.
module tb_gf180mcu_fd_sc_mcu7t5v0__arb33_1;

  logic       clk;
  logic       rst;
  logic [2:0] a, b;
  logic [2:0] ga, gb;
  logic       busy, conflictn;
  logic [2:0] a4, b4;
  logic [2:0] ga4, gb4;
  logic       busy4, conflictn4;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;
  int         checks;
  int         errors;

  gf180mcu_fd_sc_mcu7t5v0__arb33_1 dut (
    .CLK(clk), .RST(rst),
    .A1(a[0]), .A2(a[1]), .A3(a[2]),
    .B1(b[0]), .B2(b[1]), .B3(b[2]),
    .GA1(ga[0]), .GA2(ga[1]), .GA3(ga[2]),
    .GB1(gb[0]), .GB2(gb[1]), .GB3(gb[2]),
    .BUSY(busy), .CONFLICTN(conflictn),
    .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu7t5v0__arb33_1 #(.HOLD_MAX(4)) dut4 (
    .CLK(clk), .RST(rst),
    .A1(a4[0]), .A2(a4[1]), .A3(a4[2]),
    .B1(b4[0]), .B2(b4[1]), .B3(b4[2]),
    .GA1(ga4[0]), .GA2(ga4[1]), .GA3(ga4[2]),
    .GB1(gb4[0]), .GB2(gb4[1]), .GB3(gb4[2]),
    .BUSY(busy4), .CONFLICTN(conflictn4),
    .VDD(vdd), .VSS(vss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    a = 3'b000; b = 3'b000; a4 = 3'b000; b4 = 3'b000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a = 3'b111; b = 3'b111; a4 = 3'b000; b4 = 3'b000;
    #3;
    checks++;
    if ({ga, gb, busy, conflictn} !== 8'b0000_0001) begin
      errors++;
      $display("FAIL reset_outputs: got ga=%b gb=%b busy=%b cn=%b, want 000 000 0 1",
               ga, gb, busy, conflictn);
    end
    tick();
    checks++;
    if ({ga, gb, busy, conflictn} !== 8'b0000_0001) begin
      errors++;
      $display("FAIL reset_held_edge: got ga=%b gb=%b busy=%b cn=%b, want 000 000 0 1",
               ga, gb, busy, conflictn);
    end
  endtask

  task automatic test_all_high;
    logic [5:0] seq [7];
    seq[0] = 6'b000_001; seq[1] = 6'b001_000; seq[2] = 6'b000_010; seq[3] = 6'b010_000;
    seq[4] = 6'b000_100; seq[5] = 6'b100_000; seq[6] = 6'b000_001;
    do_reset();
    a = 3'b111; b = 3'b111;
    tick();
    checks++;
    if (conflictn !== 1'b0) begin
      errors++;
      $display("FAIL all_high_conflictn: got %b want 0", conflictn);
    end
    for (int k = 0; k < 7; k++) begin
      for (int c = 0; c < 15; c++) begin
        checks++;
        if ({gb, ga, busy} !== {seq[k], 1'b1}) begin
          errors++;
          $display("FAIL all_high_grant k=%0d c=%0d: got gb=%b ga=%b busy=%b want %b busy=1",
                   k, c, gb, ga, busy, seq[k]);
        end
        tick();
      end
      if (k < 6) begin
        checks++;
        if ({gb, ga, busy} !== 7'b0) begin
          errors++;
          $display("FAIL all_high_gap k=%0d: got gb=%b ga=%b busy=%b want all 0",
                   k, gb, ga, busy);
        end
        tick();
      end
    end
  endtask

  task automatic test_hold4;
    do_reset();
    b4 = 3'b010;
    tick();
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if ({ga4, gb4, busy4} !== 7'b000_010_1) begin
          errors++;
          $display("FAIL hold4_high p=%0d c=%0d: got ga=%b gb=%b busy=%b want 000 010 1",
                   p, c, ga4, gb4, busy4);
        end
        tick();
      end
      checks++;
      if ({ga4, gb4, busy4} !== 7'b0) begin
        errors++;
        $display("FAIL hold4_gap p=%0d: got ga=%b gb=%b busy=%b want all 0",
                 p, ga4, gb4, busy4);
      end
      tick();
    end
    b4 = 3'b000;
  endtask

  task automatic test_pulse;
    do_reset();
    a = 3'b100;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({ga, gb, busy} !== 7'b100_000_1) begin
        errors++;
        $display("FAIL pulse_high c=%0d: got ga=%b gb=%b busy=%b want 100 000 1",
                 c, ga, gb, busy);
      end
    end
    a = 3'b000;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({ga, gb, busy, conflictn} !== 8'b000_000_0_1) begin
        errors++;
        $display("FAIL pulse_low c=%0d: got ga=%b gb=%b busy=%b cn=%b want 000 000 0 1",
                 c, ga, gb, busy, conflictn);
      end
    end
  endtask

  task automatic test_conflict;
    do_reset();
    a = 3'b001;
    tick();
    checks++;
    if ({ga, gb, conflictn} !== 7'b001_000_1) begin
      errors++;
      $display("FAIL conflict_ga1: got ga=%b gb=%b cn=%b want 001 000 1", ga, gb, conflictn);
    end
    b = 3'b111;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({ga, gb, conflictn} !== 7'b001_000_0) begin
        errors++;
        $display("FAIL conflict_hold c=%0d: got ga=%b gb=%b cn=%b want 001 000 0",
                 c, ga, gb, conflictn);
      end
    end
    a = 3'b000;
    tick();
    checks++;
    if ({ga, gb, busy, conflictn} !== 8'b000_000_0_1) begin
      errors++;
      $display("FAIL conflict_recover: got ga=%b gb=%b busy=%b cn=%b want 000 000 0 1",
               ga, gb, busy, conflictn);
    end
    tick();
    checks++;
    if ({ga, gb, busy} !== 7'b000_001_1) begin
      errors++;
      $display("FAIL conflict_gb1: got ga=%b gb=%b busy=%b want 000 001 1", ga, gb, busy);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    b = 3'b100;
    tick();
    checks++;
    if ({ga, gb} !== 6'b000_100) begin
      errors++;
      $display("FAIL async_gb3: got ga=%b gb=%b want 000 100", ga, gb);
    end
    a = 3'b010;
    tick();
    checks++;
    if ({ga, gb, conflictn} !== 7'b000_100_0) begin
      errors++;
      $display("FAIL async_gb3_hold: got ga=%b gb=%b cn=%b want 000 100 0", ga, gb, conflictn);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ga, gb, busy, conflictn} !== 8'b000_000_0_1) begin
      errors++;
      $display("FAIL async_reset_mid: got ga=%b gb=%b busy=%b cn=%b want 000 000 0 1",
               ga, gb, busy, conflictn);
    end
    a = 3'b010; b = 3'b001;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({ga, gb} !== 6'b010_000) begin
      errors++;
      $display("FAIL async_after_release: got ga=%b gb=%b want 010 000", ga, gb);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_all_high();
    test_hold4();
    test_pulse();
    test_conflict();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__arb33_1.md
GF180MCU_FD_SC_MCU7T5V0__ARB33_1 -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__arb33_1

Interface
REQ-001 SHALL provide parameter HOLD_MAX, default 15, meaning the maximum consecutive grant cycles per tenure; legal range 1..15.
REQ-002 SHALL provide port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL provide port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL provide ports A1, A2, A3, input, 1 bit each: group-A requests.
REQ-005 SHALL provide ports B1, B2, B3, input, 1 bit each: group-B requests.
REQ-006 SHALL provide ports GA1, GA2, GA3, output, 1 bit each: group-A grants.
REQ-007 SHALL provide ports GB1, GB2, GB3, output, 1 bit each: group-B grants.
REQ-008 SHALL provide port BUSY, output, 1 bit: high while any grant is high.
REQ-009 SHALL provide port CONFLICTN, output, 1 bit: registered value of !((A1|A2|A3)&(B1|B2|B3)).
REQ-010 SHALL provide ports VDD and VSS, inout, 1 bit each: supply pins with no functional behaviour.

Function
REQ-011 SHALL drive at most one of the six grants high in any cycle; all grants SHALL be registered outputs.
REQ-012 SHALL implement three states: IDLE, GRANT and RECOVER.
REQ-013 In IDLE or RECOVER with any request high, SHALL go to GRANT and assert the winning grant on the next edge (1-cycle latency).
REQ-014 In IDLE or RECOVER with no request, SHALL go to or stay in IDLE.
REQ-015 Group choice: only one group requesting wins; both requesting, the group not equal to LASTGRP wins.
REQ-016 LASTGRP SHALL update to the winning group at every grant entry.
REQ-017 Within a group, SHALL pick the first requester after that group's pointer in cyclic order 1→2→3→1, then set the pointer to the winner.
REQ-018 Each group's pointer SHALL change only when that group wins.
REQ-019 HOLDCNT, 4 bits, SHALL clear on GRANT entry and increment each GRANT cycle.
REQ-020 In GRANT, SHALL go to RECOVER, with all grants low on the next edge, when the granted request is low or HOLDCNT equals HOLD_MAX-1.
REQ-021 A grant SHALL therefore last at most HOLD_MAX cycles, followed by exactly one all-low RECOVER cycle (break-before-make).
REQ-022 In GRANT, request changes on non-granted inputs SHALL be ignored.
REQ-023 A requester force-released by HOLD_MAX SHALL be re-arbitrated in RECOVER like any other requester.
REQ-024 BUSY SHALL equal the OR of the six grants, registered in the same edge.
REQ-025 CONFLICTN SHALL follow the inputs with exactly 1-cycle latency, independent of state.

Reset
REQ-026 While RST=1, SHALL force state=IDLE, all grants=0, BUSY=0, CONFLICTN=1, HOLDCNT=0, both pointers=3 and LASTGRP=B, asynchronously, including mid-grant.
REQ-027 SHALL begin arbitrating at the first rising CLK edge after RST falls, with A1 winning if all requests are high.

Structure
REQ-028 SHALL define in a shared package: the state enum (IDLE, GRANT, RECOVER), the group encoding (GRP_A, GRP_B), the HOLDCNT width (4) and the pointer reset value (3).
REQ-029 SHALL instantiate one sub-module, gf180mcu_fd_sc_mcu7t5v0__rr3pick, twice (once per group); it is combinational and maps 3 requests plus a pointer to a one-hot winner plus a valid signal.
REQ-030 Block size SHALL be 120-400 lines of RTL.

Verification
REQ-031 Reset, then A1=A2=A3=B1=B2=B3=1 held → grant order GA1, GB1, GA2, GB2, GA3, GB3, GA1, with each grant 15 cycles long and separated by 1 low cycle.
REQ-032 HOLD_MAX=4, only B2 held high → GB2 high for 4 cycles, low for 1 cycle, high again for 4 cycles, repeating; BUSY mirrors GB2.
REQ-033 A3 pulsed high for 3 cycles from idle → GA3 rises 1 cycle after A3, stays high 2 cycles after A3 rises, falls 1 cycle after A3 falls; RECOVER then IDLE.
REQ-034 While GA1 is held, assert B1..B3 → no grant change; CONFLICTN goes 0 one cycle after both groups are requesting; GB1 is granted after GA1 drops plus 1 cycle.
REQ-035 Assert RST asynchronously mid-GB3 tenure → all grants, BUSY and HOLDCNT go to 0 and CONFLICTN goes to 1 without a clock edge; after release with A2 and B1 high, GA2 wins first.
